dmem_mmio: RTL and testbench

- Data-memory subsystem directly downstream of the single-cycle RV32 core's data port.
- Consumes the core's address, write-enable and write-data and returns read data in the same cycle.
- Contains a word-addressed RAM plus memory-mapped peripherals: LED register, UART transmitter with TX FIFO, status register and free-running cycle counter.

---
 rtl/dmem_mmio.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_dmem_mmio.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory subsystem sitting on the RV32 core's data port.
// Holds a word-addressed RAM and a small block of memory-mapped peripherals:
// an LED register, a UART transmitter (8N1) fed by a TX FIFO, a status
// register and a free-running cycle counter.
//
// Build option: define DMEM_MMIO_CYCLES_EN to implement the CYCLES counter.
// Without it, CYCLES reads as 0 and writes to it are ignored.
//
// Address map (word accesses, addr[1:0] ignored):
//   0x0000_0000 .. 4*RAM_WORDS-1  RAM
//   0x8000_0000                   LED     {26'b0, led}
//   0x8000_0004                   TXDATA  write pushes wdata[7:0], reads 0
//   0x8000_0008                   STATUS  {28'b0, ovf, busy, empty, full}
//   0x8000_000C                   CYCLES  32-bit cycle counter
//
// UART FSM:
//   state   | meaning
//   S_IDLE  | line high; pops the FIFO head as soon as the FIFO is non-empty
//   S_START | start bit (low) for CLK_DIV cycles
//   S_DATA  | eight data bits, LSB first, CLK_DIV cycles each
//   S_STOP  | stop bit (high) for CLK_DIV cycles, then back to S_IDLE

module dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int CLK_DIV    = 234,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [5:0]  led,
  output logic        uart_tx
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int BW     = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  // Word addresses (addr[31:2]) of the peripheral registers.
  localparam logic [29:0] WA_LED    = 30'h2000_0000;
  localparam logic [29:0] WA_TXDATA = 30'h2000_0001;
  localparam logic [29:0] WA_STATUS = 30'h2000_0002;
  localparam logic [29:0] WA_CYCLES = 30'h2000_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic              sel_ram;
  logic              sel_led;
  logic              sel_tx;
  logic              sel_status;
  logic              sel_cycles;
  logic [RAM_AW-1:0] ram_idx;

  assign sel_ram    = (addr[31:RAM_AW+2] == '0);
  assign sel_led    = (addr[31:2] == WA_LED);
  assign sel_tx     = (addr[31:2] == WA_TXDATA);
  assign sel_status = (addr[31:2] == WA_STATUS);
  assign sel_cycles = (addr[31:2] == WA_CYCLES);
  assign ram_idx    = addr[RAM_AW+1:2];

  // ---------------------------------------------------------------------
  // RAM: asynchronous read, synchronous write, no reset
  // ---------------------------------------------------------------------
  logic [31:0] mem [RAM_WORDS];

  // Store a word on a write to the RAM window.
  always_ff @(posedge clk) begin
    if (we && sel_ram) begin
      mem[ram_idx] <= wdata;
    end
  end

  // ---------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------
  // Latch the low six write-data bits on a write to LED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 6'd0;
    end else if (we && sel_led) begin
      led <= wdata[5:0];
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO: pointers carry one extra bit to tell full from empty
  // ---------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        ovf;
  logic [7:0]  fifo_head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push      = we && sel_tx && !full;
  assign fifo_head = fifo_mem[rd_ptr[PW-1:0]];

  // Write the pushed byte into the slot the write pointer names.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= wdata[7:0];
    end
  end

  // Advance the pointers; push and pop may happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky overflow: set by a push into a full FIFO (full is judged before
  // the edge, so a simultaneous pop does not rescue the byte), cleared by a
  // STATUS write with bit 3 set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (we && sel_tx && full) begin
      ovf <= 1'b1;
    end else if (we && sel_status && wdata[3]) begin
      ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------
  state_t        state_q;
  state_t        state_d;
  logic [BW-1:0] baud_cnt;
  logic          baud_tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          busy;

  assign baud_tick = (baud_cnt == '0);
  assign busy      = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and FIFO pop request.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick && (bit_idx == 3'd7)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Baud down-counter: reloads on frame start and at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (pop || (busy && baud_tick)) begin
      baud_cnt <= BAUD_RELOAD;
    end else if (busy) begin
      baud_cnt <= baud_cnt - 1'b1;
    end
  end

  // Shift register and bit index: load on pop, shift right per data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= 8'd0;
      bit_idx <= 3'd0;
    end else if (pop) begin
      shift_q <= fifo_head;
      bit_idx <= 3'd0;
    end else if (baud_tick) begin
      if (state_q == S_START) begin
        bit_idx <= 3'd0;
      end else if (state_q == S_DATA) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Line level is a pure function of state so reset forces it high at once.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      S_IDLE:  uart_tx = 1'b1;
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      S_STOP:  uart_tx = 1'b1;
      default: uart_tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------
`ifdef DMEM_MMIO_CYCLES_EN
  logic [31:0] cycle_cnt;

  // Free-running count; a write to CYCLES takes priority and zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 32'd0;
    end else if (we && sel_cycles) begin
      cycle_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Read mux (combinational, no side effects)
  // ---------------------------------------------------------------------
  // Select read data from whichever region the address falls in.
  always_comb begin
    rdata = 32'd0;
    if (sel_ram) begin
      rdata = mem[ram_idx];
    end else if (sel_led) begin
      rdata = {26'd0, led};
    end else if (sel_status) begin
      rdata = {28'd0, ovf, busy, empty, full};
    end else if (sel_cycles) begin
`ifdef DMEM_MMIO_CYCLES_EN
      rdata = cycle_cnt;
`else
      rdata = 32'd0;
`endif
    end
  end

  // Byte-offset bits play no part in a word-only bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

endmodule

// File: tb/tb_dmem_mmio.sv
// Testbench for dmem_mmio with CLK_DIV=4, FIFO_DEPTH=8, RAM_WORDS=1024.
// Register map behaviour is driven from a vector table; UART framing, FIFO
// overflow, reset mid-frame and the cycle counter are hand-written sequences.

module tb_dmem_mmio;

  localparam int CLK_DIV = 4;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_CYCLES = 32'h8000_000C;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  led;
  logic        uart_tx;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] rx_q[$];
  logic       mon_en;

  dmem_mmio #(
    .RAM_WORDS (1024),
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .led    (led),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [5:0]  exp_led;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One write transaction; returns 1 time unit after the capturing edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serial monitor: samples the line mid-bit and collects received bytes.
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst && uart_tx == 1'b0) begin
        tick(6);
        b[0] = uart_tx;
        for (int i = 1; i < 8; i++) begin
          tick(CLK_DIV);
          b[i] = uart_tx;
        end
        tick(CLK_DIV);
        check("stop_bit", {31'd0, uart_tx}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    logic [31:0] v;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [7:0]  frame_byte;
    int          exp_bit;
    int          lows;
    int          waited;

    //  addr           we    wdata          chk   exp_rd          exp_led
    vt[0]  = '{A_LED,        1'b0, 32'h0,         1'b1, 32'h0,         6'h00};
    vt[1]  = '{32'h14,       1'b1, 32'h1234_5678, 1'b0, 32'h0,         6'h00};
    vt[2]  = '{32'h10,       1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         6'h00};
    vt[3]  = '{32'h10,       1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 6'h00};
    vt[4]  = '{32'h13,       1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 6'h00};
    vt[5]  = '{32'h14,       1'b0, 32'h0,         1'b1, 32'h1234_5678, 6'h00};
    vt[6]  = '{A_LED,        1'b1, 32'hFFFF_FFE5, 1'b1, 32'h0,         6'h25};
    vt[7]  = '{A_LED,        1'b0, 32'h0,         1'b1, 32'h25,        6'h25};
    vt[8]  = '{32'h4000_0000,1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,         6'h25};
    vt[9]  = '{32'h4000_0000,1'b0, 32'h0,         1'b1, 32'h0,         6'h25};
    vt[10] = '{A_TXDATA,     1'b0, 32'h0,         1'b1, 32'h0,         6'h25};
    vt[11] = '{A_STATUS,     1'b0, 32'h0,         1'b1, 32'h2,         6'h25};
    vt[12] = '{A_LED,        1'b1, 32'h0000_0003, 1'b1, 32'h25,        6'h03};
    vt[13] = '{32'h0000_1000,1'b0, 32'h0,         1'b1, 32'h0,         6'h03};
    vt[14] = '{32'h10,       1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 6'h03};
    vt[15] = '{32'h8000_0010,1'b1, 32'h0000_0001, 1'b1, 32'h0,         6'h03};

    mon_en = 1'b1;
    rst    = 1'b1;
    addr   = A_STATUS;
    we     = 1'b0;
    wdata  = 32'd0;
    #1;
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_led", {26'd0, led}, 32'd0);
    check("rst_status", rdata, 32'h2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Register/RAM vector table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      addr  = vt[i].a;
      we    = vt[i].w;
      wdata = vt[i].d;
      #1;
      if (vt[i].chk_rd) check($sformatf("vec%0d_rd", i), rdata, vt[i].exp_rd);
      @(posedge clk);
      #1;
      we = 1'b0;
      check($sformatf("vec%0d_led", i), {26'd0, led}, {26'd0, vt[i].exp_led});
    end

    // Single frame of 0x55.
    wr(A_TXDATA, 32'h0000_0055);
    addr = A_STATUS;
    #1;
    check("frame_pre_status", rdata, 32'h0);
    check("frame_pre_tx", {31'd0, uart_tx}, 32'd1);
    frame_byte = 8'h55;
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      tick(1);
      if (k / CLK_DIV == 0)      exp_bit = 0;
      else if (k / CLK_DIV == 9) exp_bit = 1;
      else                       exp_bit = int'(frame_byte[k / CLK_DIV - 1]);
      check($sformatf("frame_tx_k%0d", k), {31'd0, uart_tx}, exp_bit);
      check($sformatf("frame_status_k%0d", k), rdata, 32'h6);
    end
    tick(1);
    check("frame_post_status", rdata, 32'h2);
    check("frame_post_tx", {31'd0, uart_tx}, 32'd1);
    tick(4);
    check("frame_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("frame_rx_byte", {24'd0, rx_q[0]}, 32'h55);
    rx_q.delete();

    // FIFO fill and overflow: 10 back-to-back pushes, one gets popped.
    for (int i = 0; i < 9; i++) wr(A_TXDATA, 32'h11 + i);
    rd(A_STATUS, v);
    check("ovf_after9_status", v, 32'h5);
    wr(A_TXDATA, 32'h1A);
    rd(A_STATUS, v);
    check("ovf_after10_status", v, 32'hD);
    wr(A_STATUS, 32'h0000_0007);
    rd(A_STATUS, v);
    check("ovf_clear_bit3_low", v, 32'hD);
    wr(A_STATUS, 32'h0000_0008);
    rd(A_STATUS, v);
    check("ovf_cleared_status", v, 32'h5);
    waited = 0;
    while (rx_q.size() < 9 && waited < 800) begin
      tick(1);
      waited++;
    end
    check("ovf_rx_timeout", (waited < 800) ? 32'd1 : 32'd0, 32'd1);
    tick(60);
    check("ovf_rx_count", rx_q.size(), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check($sformatf("ovf_rx_byte%0d", i), {24'd0, rx_q[i]}, 32'h11 + i);
    rd(A_STATUS, v);
    check("ovf_drained_status", v, 32'h2);

    // Reset during the DATA phase of a 0x00 frame with another byte queued.
    mon_en = 1'b0;
    wr(A_TXDATA, 32'h00);
    wr(A_TXDATA, 32'h3C);
    tick(14);
    check("mid_pre_rst_tx", {31'd0, uart_tx}, 32'd0);
    addr = A_STATUS;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_busy", {31'd0, rdata[2]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(A_STATUS, v);
    check("mid_post_status", v, 32'h2);
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (uart_tx !== 1'b1) lows++;
    end
    check("mid_no_output", lows, 32'd0);
    check("mid_final_status", rdata, 32'h2);

    // Cycle counter.
`ifdef DMEM_MMIO_CYCLES_EN
    addr = A_CYCLES;
    tick(1);
    c1 = rdata;
    tick(5);
    c2 = rdata;
    check("cyc_diff5", c2 - c1, 32'd5);
    wr(A_CYCLES, 32'hFFFF_FFFF);
    addr = A_CYCLES;
    #1;
    check("cyc_clear", rdata, 32'd0);
    tick(3);
    check("cyc_after_clear3", rdata, 32'd3);
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    #1;
    check("cyc_preload", rdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("cyc_wrap", rdata, 32'd0);
`else
    c1 = 32'd0;
    c2 = 32'd0;
    rd(A_CYCLES, v);
    check("cyc_off_read", v, 32'd0);
    wr(A_CYCLES, 32'h1234);
    tick(5);
    rd(A_CYCLES, v);
    check("cyc_off_after_write", v, c1 + c2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
